// File: rtl/seq_detect_ctrl_if.sv
// rtl/seq_detect_ctrl_if.sv - control/config/serial/status bundle for seq_detect_ctrl
//
// Purpose: groups every signal of seq_detect_ctrl except clk and rst.
//   master: software/bit-source side (drives config, start, abort, serial bits)
//   slave : the detector controller (drives detect and the status outputs)
// Signals:
//   cfg_we, cfg_pattern[MAX_LEN], cfg_len[4], cfg_overlap, cfg_target[CNT_W],
//   cfg_timeout[TO_W]                       configuration load
//   start, abort                            run control pulses
//   in, in_valid                            serial data bit and its qualifier
//   detect                                  1-cycle match pulse
//   match_count[CNT_W], busy, done, timed_out   status

interface seq_detect_ctrl_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int TO_W    = 16
);
   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [3:0]         cfg_len;
   logic               cfg_overlap;
   logic [CNT_W-1:0]   cfg_target;
   logic [TO_W-1:0]    cfg_timeout;
   logic               start;
   logic               abort;
   logic               in;
   logic               in_valid;
   logic               detect;
   logic [CNT_W-1:0]   match_count;
   logic               busy;
   logic               done;
   logic               timed_out;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
      output start, abort, in, in_valid,
      input  detect, match_count, busy, done, timed_out
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
      input  start, abort, in, in_valid,
      output detect, match_count, busy, done, timed_out
   );
endinterface

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial pattern detector with run control
//
// Purpose: holds the pattern/length/overlap/target/timeout configuration, arms and
//   disarms the search, counts matches and ends a run on a target match count or
//   an idle timeout.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-high
//   bus  seq_detect_ctrl_if.slave (config, start/abort, serial in, status outputs)

module seq_detect_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int TO_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   seq_detect_ctrl_if.slave   bus
);
   localparam logic [3:0] LEN_MAX = 4'(MAX_LEN);

   typedef enum logic [1:0] {IDLE, SEARCH, DONE, TIMEOUT} state_t;

   state_t state, state_nx;

   // running configuration
   logic [MAX_LEN-1:0] pat_q;
   logic [3:0]         len_q;
   logic               ovl_q;
   logic [CNT_W-1:0]   tgt_q;
   logic [TO_W-1:0]    tmo_q;
   logic [3:0]         len_clamped;

   // search datapath
   logic [MAX_LEN-1:0] hist, hist_nx;
   logic [3:0]         fill, fill_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [TO_W-1:0]    timer, timer_nx;
   logic               det, det_nx;

   logic [MAX_LEN-1:0] shifted;
   logic [MAX_LEN-1:0] mask;
   logic [3:0]         fill_inc;
   logic [CNT_W-1:0]   cnt_inc;
   logic [TO_W-1:0]    timer_inc;
   logic               hit;

   always_comb begin
      len_clamped = bus.cfg_len;
      if (bus.cfg_len < 4'd2)
         len_clamped = 4'd2;
      else if (bus.cfg_len > LEN_MAX)
         len_clamped = LEN_MAX;
   end

   // Config is frozen for the whole SEARCH state, so the datapath reads the
   // registers directly without a shadow copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_q <= MAX_LEN'(4'b1010);
         len_q <= 4'd4;
         ovl_q <= 1'b0;
         tgt_q <= '0;
         tmo_q <= '0;
      end else if (bus.cfg_we && state != SEARCH) begin
         pat_q <= bus.cfg_pattern;
         len_q <= len_clamped;
         ovl_q <= bus.cfg_overlap;
         tgt_q <= bus.cfg_target;
         tmo_q <= bus.cfg_timeout;
      end
   end

   // Match test on the history as it will look after shifting in the current bit,
   // so detect can be registered on the same edge that samples the final bit.
   always_comb begin
      shifted   = {hist[MAX_LEN-2:0], bus.in};
      fill_inc  = (fill == LEN_MAX) ? fill : fill + 4'd1;
      cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
      timer_inc = timer + TO_W'(1);
      mask      = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (i < int'(len_q));
      hit = bus.in_valid && (fill_inc >= len_q) && (((shifted ^ pat_q) & mask) == '0);
   end

   always_comb begin
      state_nx = state;
      hist_nx  = hist;
      fill_nx  = fill;
      cnt_nx   = cnt;
      timer_nx = timer;
      det_nx   = 1'b0;
      if (bus.abort) begin
         state_nx = IDLE;
         hist_nx  = '0;
         fill_nx  = '0;
      end else begin
         case (state)
            SEARCH: begin
               if (bus.in_valid) begin
                  hist_nx = shifted;
                  fill_nx = fill_inc;
               end
               if (hit) begin
                  det_nx   = 1'b1;
                  cnt_nx   = cnt_inc;
                  timer_nx = '0;
                  if (!ovl_q) begin
                     hist_nx = '0;
                     fill_nx = '0;
                  end
                  if (tgt_q != '0 && cnt_inc == tgt_q)
                     state_nx = DONE;
               end else begin
                  timer_nx = timer_inc;
                  if (tmo_q != '0 && timer_inc == tmo_q)
                     state_nx = TIMEOUT;
               end
            end
            default: begin
               if (bus.start) begin
                  state_nx = SEARCH;
                  hist_nx  = '0;
                  fill_nx  = '0;
                  cnt_nx   = '0;
                  timer_nx = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist  <= '0;
         fill  <= '0;
         cnt   <= '0;
         timer <= '0;
         det   <= 1'b0;
      end else begin
         hist  <= hist_nx;
         fill  <= fill_nx;
         cnt   <= cnt_nx;
         timer <= timer_nx;
         det   <= det_nx;
      end
   end

   // done/timed_out are levels tied to their states: start leaves them via
   // SEARCH and abort via IDLE, which clears both.
   assign bus.detect      = det;
   assign bus.match_count = cnt;
   assign bus.busy        = (state == SEARCH);
   assign bus.done        = (state == DONE);
   assign bus.timed_out   = (state == TIMEOUT);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - scoreboard bench for seq_detect_ctrl

module tb_seq_detect_ctrl;
   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 8;
   localparam int TO_W    = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TO_W(TO_W)) bus ();

   seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int edge_no  = 0;

   typedef struct {
      int edge_no;
      int count;
   } exp_t;
   exp_t sb[$];

   // reference model: 0 idle, 1 searching, 2 target reached, 3 timed out
   int         m_run;
   int         m_count;
   int         m_timer;
   bit         m_bits[$];
   bit [7:0]   m_pat;
   int         m_len;
   bit         m_ovl;
   int         m_tgt;
   int         m_tmo;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   task automatic model_reset();
      m_run   = 0;
      m_count = 0;
      m_timer = 0;
      m_bits.delete();
      m_pat   = 8'b0000_1010;
      m_len   = 4;
      m_ovl   = 1'b0;
      m_tgt   = 0;
      m_tmo   = 0;
   endtask

   task automatic model_edge(bit s, bit a, bit b, bit v);
      int  old = m_run;
      bit  hit;
      if (bus.cfg_we && old != 1) begin
         m_pat = bus.cfg_pattern;
         m_len = int'(bus.cfg_len);
         if (m_len < 2) m_len = 2;
         if (m_len > MAX_LEN) m_len = MAX_LEN;
         m_ovl = bus.cfg_overlap;
         m_tgt = int'(bus.cfg_target);
         m_tmo = int'(bus.cfg_timeout);
      end
      if (a) begin
         m_run = 0;
         m_bits.delete();
      end else if (old != 1) begin
         if (s) begin
            m_run   = 1;
            m_bits.delete();
            m_count = 0;
            m_timer = 0;
         end
      end else begin
         hit = 1'b0;
         if (v) begin
            m_bits.push_back(b);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            if (m_bits.size() >= m_len) begin
               hit = 1'b1;
               for (int k = 0; k < m_len; k++)
                  if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
            end
         end
         if (hit) begin
            if (m_count < 255) m_count++;
            sb.push_back('{edge_no, m_count});
            m_timer = 0;
            if (!m_ovl) m_bits.delete();
            if (m_tgt != 0 && m_count == m_tgt) m_run = 2;
         end else begin
            m_timer++;
            if (m_tmo != 0 && m_timer == m_tmo) m_run = 3;
         end
      end
   endtask

   // one clock: drive at negedge, model at posedge, check status at next negedge
   task automatic step(bit s, bit a, bit b, bit v);
      bus.start    = s;
      bus.abort    = a;
      bus.in       = b;
      bus.in_valid = v;
      @(posedge clk);
      edge_no++;
      model_edge(s, a, b, v);
      @(negedge clk);
      bus.cfg_we = 1'b0;
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      check("busy",        int'(bus.busy),        int'(m_run == 1));
      check("done",        int'(bus.done),        int'(m_run == 2));
      check("timed_out",   int'(bus.timed_out),   int'(m_run == 3));
      check("match_count", int'(bus.match_count), m_count);
   endtask

   task automatic send(bit [15:0] bits, int n);
      for (int i = n - 1; i >= 0; i--)
         step(1'b0, 1'b0, bits[i], 1'b1);
   endtask

   task automatic load_cfg(bit [7:0] p, bit [3:0] l, bit o, int t, int tmo);
      bus.cfg_pattern = p;
      bus.cfg_len     = l;
      bus.cfg_overlap = o;
      bus.cfg_target  = CNT_W'(t);
      bus.cfg_timeout = TO_W'(tmo);
      bus.cfg_we      = 1'b1;
   endtask

   // monitor: every detect pulse pops one expected match
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.detect) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL detect_unexpected: detect=1 with no expected match (edge %0d)", edge_no);
            end else begin
               e = sb.pop_front();
               if (e.edge_no != edge_no || e.count != int'(bus.match_count)) begin
                  failures++;
                  $display("FAIL detect_match: edge %0d count %0d, expected edge %0d count %0d",
                           edge_no, bus.match_count, e.edge_no, e.count);
               end
            end
         end else if (sb.size() > 0 && sb[0].edge_no <= edge_no) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL detect_missing: detect=0 at edge %0d, expected pulse with count %0d",
                     edge_no, e.count);
         end
      end
   end

   initial begin
      bit s, a, v;
      rst             = 1'b1;
      bus.cfg_we      = 1'b0;
      bus.cfg_pattern = '0;
      bus.cfg_len     = '0;
      bus.cfg_overlap = 1'b0;
      bus.cfg_target  = '0;
      bus.cfg_timeout = '0;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.in          = 1'b0;
      bus.in_valid    = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_detect",      int'(bus.detect),      0);
      check("rst_match_count", int'(bus.match_count), 0);
      check("rst_busy",        int'(bus.busy),        0);
      check("rst_done",        int'(bus.done),        0);
      check("rst_timed_out",   int'(bus.timed_out),   0);
      rst = 1'b0;

      // defaults, non-overlapping 1010
      step(1, 0, 0, 0);
      send(16'b1010_1010, 8);
      check("dflt_count", int'(bus.match_count), 2);
      check("dflt_busy",  int'(bus.busy),        1);
      step(0, 1, 0, 0);

      // overlapping
      load_cfg(8'b1010, 4, 1, 0, 0);
      step(1, 0, 0, 0);
      send(16'b10_1010, 6);
      check("ovl_count", int'(bus.match_count), 2);
      step(0, 1, 0, 0);

      // target of 2, then further pattern ignored
      load_cfg(8'b1010, 4, 0, 2, 0);
      step(1, 0, 0, 0);
      send(16'b1010_1010, 8);
      check("tgt_done", int'(bus.done), 1);
      check("tgt_busy", int'(bus.busy), 0);
      send(16'b1010, 4);
      check("tgt_count_hold", int'(bus.match_count), 2);

      // timeout of 5 with no valid bits
      load_cfg(8'b1010, 4, 0, 0, 5);
      step(1, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0);
      check("to_busy_4th", int'(bus.busy), 1);
      step(0, 0, 0, 0);
      check("to_flag_5th", int'(bus.timed_out), 1);
      check("to_busy_5th", int'(bus.busy),      0);
      step(1, 0, 0, 0);
      check("to_cleared", int'(bus.timed_out), 0);
      step(0, 1, 0, 0);

      // abort discards a partial pattern; cfg_we during SEARCH is ignored
      load_cfg(8'b1010, 4, 0, 0, 0);
      step(1, 0, 0, 0);
      send(16'b101, 3);
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      send(16'b0, 1);
      check("abort_no_match", int'(bus.match_count), 0);
      load_cfg(8'b101, 3, 0, 0, 0);
      send(16'b1010, 4);
      check("cfg_locked", int'(bus.match_count), 1);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            load_cfg(8'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                                : 4'($urandom_range(2, 4)),
                     1'($urandom), $urandom_range(0, 4),
                     ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, 25));
         end
         s = ($urandom_range(0, 11) == 0);
         a = ($urandom_range(0, 79) == 0);
         v = ($urandom_range(0, 3) != 0);
         step(s, a, 1'($urandom), v);
      end

      // reset between edges in the middle of a run
      load_cfg(8'b1010, 4, 0, 0, 0);
      step(1, 0, 0, 0);
      send(16'b1010_10, 6);
      #2;
      rst = 1'b1;
      #1;
      check("arst_detect",      int'(bus.detect),      0);
      check("arst_match_count", int'(bus.match_count), 0);
      check("arst_busy",        int'(bus.busy),        0);
      check("arst_done",        int'(bus.done),        0);
      check("arst_timed_out",   int'(bus.timed_out),   0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1, 0, 0, 0);
      send(16'b1010, 4);
      check("arst_cfg_default", int'(bus.match_count), 1);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
